countdown_seg_display: RTL and testbench
========================================

// Module: countdown_seg_display
// PURPOSE
//   Downstream display stage for the traffic-light controller. Accepts the binary
//   countdown value (0..99) over a valid/ready handshake, converts it to two BCD digits
//   with an iterative shift-add-3 converter, and drives a 2-digit multiplexed
//   common-anode 8-segment display. Supports leading-zero blanking, a blank-all
//   (blink) input and a decimal point.
// PARAMETERS
//   CLK_FREQ  50_000_000  system clock frequency, Hz
//   SCAN_HZ   1_000       digit switch rate, Hz; SCAN_DIV = CLK_FREQ/SCAN_HZ cycles per digit
// PORTS
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous reset, active-low
//   val_valid  in   1  val_bin is valid this cycle
//   val_bin    in   7  binary value; >99 saturates to 99
//   val_ready  out  1  converter idle, can accept a value
//   blank_lz   in   1  1: blank the tens digit when it is 0
//   blank_all  in   1  1: all segments off (yellow-blink phase)
//   dp_on      in   1  1: light the decimal point on the ones digit
//   seg_out    out  8  {dp,g,f,e,d,c,b,a}, active-low, registered
//   seg_sel    out  2  digit enable, active-low: 2'b10 = ones, 2'b01 = tens; registered
// BEHAVIOUR
//   Reset (async): FSM=IDLE, val_ready=1, disp_tens=disp_ones=0, scan_cnt=0,
//     scan_ph=0 (ones), seg_out=8'hFF, seg_sel=2'b11 until the first scan tick.
//   Handshake: transfer on the edge where val_valid && val_ready. val_ready=1 only in IDLE.
//     val_valid while busy is ignored, not queued.
//   FSM IDLE -> SHIFT on transfer. Capture edge T: load min(val_bin,99) into shift reg,
//     clear the 8-bit BCD accumulator, set iter=0.
//   SHIFT: edges T+1..T+7, one iteration each: add 3 to each BCD nibble >=5, then shift
//     {bcd,bin} left by 1.
//   On edge T+7: write the result to disp_tens/disp_ones (both digits update on the
//     same edge), then go to IDLE. val_ready=1 again in cycle T+8. Back-to-back accepts
//     are spaced 8 cycles apart.
//   Display regs hold their value until the next completed conversion.
//   Scan: scan_cnt counts 0..SCAN_DIV-1. At wrap (tick): scan_ph toggles, and
//     seg_sel/seg_out are registered for the new phase.
//     Phase ones -> seg_sel=2'b10; phase tens -> seg_sel=2'b01.
//   Decode, active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90;
//     dp bit = 1 (off) unless lit. A digit value >9 is not possible; default is 8'hFF.
//   Priority per tick:
//     blank_all=1 -> seg_out=8'hFF.
//     Else tens phase with blank_lz=1 and disp_tens=0 -> 8'hFF.
//     Else decode; on the ones phase, bit7 = ~dp_on.
//   blank_all/blank_lz/dp_on are sampled only at scan ticks, so their effect appears
//     at the next tick.
//   Reset mid-conversion: the conversion is aborted, display regs = 0, val_ready=1
//     after reset is released.
//   Width: scan_cnt is $clog2(SCAN_DIV) bits; iter is 3 bits; the BCD accumulator
//     never exceeds 8'h99.
// TESTING (bench: CLK_FREQ=100, SCAN_HZ=10 -> SCAN_DIV=10)
//   Reset, then idle 30 cycles -> val_ready=1; after tick 1 seg_sel=10, seg_out=C0;
//     next tick seg_sel=01, seg_out=C0.
//   One-cycle valid, val_bin=25 at edge T -> val_ready=0 for cycles T+1..T+7;
//     disp=2/5 at T+7; scan shows ones=92, tens=A4.
//   val_bin=7, blank_lz=1 -> ones=F8, tens=FF. Same with blank_lz=0 -> tens=C0.
//   val_bin=120 -> displays 99 (90/90). val_bin=99 -> 90/90. val_bin=0 -> C0/C0.
//   Load 30, then assert val_valid with 12 on cycles T+1..T+7 -> ignored, display 30.
//     Hold 12 at T+8 -> accepted, display 12.
//   blank_all=1 -> 8'hFF on both digits from the next tick. dp_on=1 -> ones bit7=0,
//     tens bit7=1.
//   rst_n low at T+4 of a load of 55 -> display C0/C0, val_ready=1 after release,
//     seg_sel=11 until the first tick.

Source files
------------

// File: rtl/countdown_seg_display.sv
// Two-digit multiplexed common-anode display stage: accepts a binary countdown value,
// converts it to BCD with a shift-add-3 loop and scans the two digits.
module countdown_seg_display #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       val_valid_i,
  input  logic [6:0] val_bin_i,
  output logic       val_ready_o,
  input  logic       blank_lz_i,
  input  logic       blank_all_i,
  input  logic       dp_on_i,
  output logic [7:0] seg_out_o,
  output logic [1:0] seg_sel_o
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t       state_q, state_d;
  logic [6:0]   bin_q, bin_d;
  logic [7:0]   bcd_q, bcd_d;
  logic [2:0]   iter_q, iter_d;
  logic [3:0]   tens_q, tens_d;
  logic [3:0]   ones_q, ones_d;
  logic [7:0]   bcd_adj;
  logic [14:0]  shifted;
  logic [6:0]   val_sat;

  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic             scan_ph_q, scan_ph_d;
  logic [7:0]       seg_q, seg_d;
  logic [1:0]       sel_q, sel_d;
  logic             tick;
  logic [3:0]       digit;
  logic [7:0]       seg_next;

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'hC0;
      4'd1:    decode = 8'hF9;
      4'd2:    decode = 8'hA4;
      4'd3:    decode = 8'hB0;
      4'd4:    decode = 8'h99;
      4'd5:    decode = 8'h92;
      4'd6:    decode = 8'h82;
      4'd7:    decode = 8'hF8;
      4'd8:    decode = 8'h80;
      4'd9:    decode = 8'h90;
      default: decode = 8'hFF;
    endcase
  endfunction

  assign val_sat = (val_bin_i > 7'd99) ? 7'd99 : val_bin_i;

  // One double-dabble step: correct nibbles >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    val_ready_o = (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (val_valid_i) begin
          state_d = S_SHIFT;
          bin_d   = val_sat;
          bcd_d   = 8'h00;
          iter_d  = 3'd0;
        end
      end
      S_SHIFT: begin
        bcd_d  = shifted[14:7];
        bin_d  = shifted[6:0];
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd6) begin
          tens_d  = shifted[14:11];
          ones_d  = shifted[10:7];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // scan_ph names the digit shown at the coming tick; it starts on the ones digit.
  assign tick  = (scan_cnt_q == CNT_MAX);
  assign digit = scan_ph_q ? tens_q : ones_q;

  always_comb begin
    seg_next = 8'hFF;
    if (blank_all_i) begin
      seg_next = 8'hFF;
    end else if (scan_ph_q && blank_lz_i && (tens_q == 4'd0)) begin
      seg_next = 8'hFF;
    end else begin
      seg_next    = decode(digit);
      seg_next[7] = scan_ph_q ? 1'b1 : ~dp_on_i;
    end
  end

  always_comb begin
    scan_cnt_d = tick ? '0 : scan_cnt_q + CNT_W'(1);
    scan_ph_d  = tick ? ~scan_ph_q : scan_ph_q;
    seg_d      = tick ? seg_next : seg_q;
    sel_d      = tick ? (scan_ph_q ? 2'b01 : 2'b10) : sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      scan_cnt_q <= '0;
      scan_ph_q  <= 1'b0;
      seg_q      <= 8'hFF;
      sel_q      <= 2'b11;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      scan_cnt_q <= scan_cnt_d;
      scan_ph_q  <= scan_ph_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign seg_out_o = seg_q;
  assign seg_sel_o = sel_q;

endmodule

// File: tb/tb_countdown_seg_display.sv
// Scoreboard bench for countdown_seg_display: expected digit patterns are queued when a
// value or control change is driven and compared against the next fresh scan pair.
module tb_countdown_seg_display;

  localparam int CLK_FREQ = 100;
  localparam int SCAN_HZ  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       val_valid;
  logic [6:0] val_bin;
  logic       val_ready;
  logic       blank_lz;
  logic       blank_all;
  logic       dp_on;
  logic [7:0] seg_out;
  logic [1:0] seg_sel;

  always #5 clk = ~clk;

  countdown_seg_display #(
    .CLK_FREQ(CLK_FREQ),
    .SCAN_HZ (SCAN_HZ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .val_valid_i(val_valid),
    .val_bin_i  (val_bin),
    .val_ready_o(val_ready),
    .blank_lz_i (blank_lz),
    .blank_all_i(blank_all),
    .dp_on_i    (dp_on),
    .seg_out_o  (seg_out),
    .seg_sel_o  (seg_sel)
  );

  typedef struct {
    string      tag;
    logic [7:0] ones;
    logic [7:0] tens;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_seg(input int d, input bit is_tens);
    logic [7:0] r;
    if (blank_all) begin
      r = 8'hFF;
    end else if (is_tens && blank_lz && d == 0) begin
      r = 8'hFF;
    end else begin
      r = seg_tbl[d];
      if (!is_tens && dp_on) r[7] = 1'b0;
    end
    return r;
  endfunction

  task automatic push_exp(input string tag, input int v);
    exp_t e;
    int   s;
    s      = (v > 99) ? 99 : v;
    e.tag  = tag;
    e.ones = model_seg(s % 10, 1'b0);
    e.tens = model_seg(s / 10, 1'b1);
    sb.push_back(e);
  endtask

  // Wait for a fresh transition of seg_sel into target (a new scan tick).
  task automatic wait_sel(input logic [1:0] target);
    int n = 0;
    while (seg_sel == target && n < 60) begin
      @(negedge clk);
      n++;
    end
    while (seg_sel != target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("scan_tick", {30'd0, seg_sel}, {30'd0, target});
  endtask

  task automatic observe();
    exp_t       e;
    logic [7:0] o;
    logic [7:0] t;
    wait_sel(2'b10);
    o = seg_out;
    wait_sel(2'b01);
    t = seg_out;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_ones"}, {24'd0, o}, {24'd0, e.ones});
    check({e.tag, "_tens"}, {24'd0, t}, {24'd0, e.tens});
    $display("txn %s: ones=%h tens=%h (exp %h/%h)", e.tag, o, t, e.ones, e.tens);
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!val_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_back"}, {31'd0, val_ready}, 32'd1);
  endtask

  task automatic load(input string tag, input int v);
    int n;
    push_exp(tag, v);
    @(negedge clk);
    check({tag, "_ready_pre"}, {31'd0, val_ready}, 32'd1);
    val_valid = 1'b1;
    val_bin   = 7'(v);
    @(posedge clk);
    @(negedge clk);
    val_valid = 1'b0;
    wait_ready(tag, n);
    check({tag, "_busy_cycles"}, n, 32'd7);
    observe();
  endtask

  // First value v0 accepted at T; v1 held valid on the following nextra edges.
  task automatic load_extra(input string tag, input int v0, input int v1,
                            input int nextra, input int expect_val);
    int n;
    @(negedge clk);
    val_valid = 1'b1;
    val_bin   = 7'(v0);
    @(posedge clk);
    @(negedge clk);
    val_bin = 7'(v1);
    for (int i = 0; i < nextra; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    val_valid = 1'b0;
    check({tag, "_ready_after_hold"}, {31'd0, val_ready}, (nextra == 7) ? 32'd1 : 32'd0);
    wait_ready(tag, n);
    push_exp(tag, expect_val);
    observe();
  endtask

  task automatic reset_mid();
    @(negedge clk);
    val_valid = 1'b1;
    val_bin   = 7'd55;
    @(posedge clk);
    @(negedge clk);
    val_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_ready", {31'd0, val_ready}, 32'd1);
    check("mid_rst_sel", {30'd0, seg_sel}, 32'd3);
    check("mid_rst_seg", {24'd0, seg_out}, 32'hFF);
    push_exp("after_rst", 0);
    observe();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    val_valid = 1'b0;
    val_bin   = 7'd0;
    blank_lz  = 1'b0;
    blank_all = 1'b0;
    dp_on     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", {31'd0, val_ready}, 32'd1);
    check("rst_sel", {30'd0, seg_sel}, 32'd3);
    check("rst_seg", {24'd0, seg_out}, 32'hFF);
    push_exp("reset", 0);
    observe();
    repeat (30) @(negedge clk);
    check("idle_ready", {31'd0, val_ready}, 32'd1);

    load("v25", 25);
    blank_lz = 1'b1;
    load("v7_blz", 7);
    load("v0_blz", 0);
    load("v10_blz", 10);
    blank_lz = 1'b0;
    load("v7", 7);
    load("v120", 120);
    load("v99", 99);
    load("v0", 0);

    load_extra("ignored", 30, 12, 7, 30);
    load_extra("accepted", 30, 12, 8, 12);

    blank_all = 1'b1;
    push_exp("blank_all", 12);
    observe();
    blank_all = 1'b0;
    dp_on = 1'b1;
    push_exp("dp_on", 12);
    observe();
    dp_on = 1'b0;

    reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
